divide: RTL

DIVIDE -- requirements
Module: divide

---
 rtl/divide.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/divide.sv
// Signed 16-bit restoring divider.
// One restoring step per clock on the operand magnitudes, 16 steps per divide.
// The quotient truncates toward zero and the remainder takes the dividend's
// sign. A zero divisor skips the iteration and reports div_by_zero instead.
module divide (
  input  logic        clk,
  input  logic        nRST,
  input  logic [15:0] INn1,
  input  logic [15:0] INn2,
  input  logic        start,
  output logic [15:0] out,
  output logic [15:0] rem,
  output logic        finish,
  output logic        div_by_zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;     // completed DIV steps
  logic [15:0] dvd_q, dvd_d;     // dividend magnitude shifting out, quotient bits shifting in
  logic [15:0] dvs_q, dvs_d;     // divisor magnitude
  logic [15:0] prem_q, prem_d;   // partial remainder (always below the divisor magnitude)
  logic        neg_q_q, neg_q_d; // quotient sign
  logic        neg_r_q, neg_r_d; // remainder sign (dividend sign)
  logic [15:0] out_q, out_d;
  logic [15:0] rem_q, rem_d;
  logic        dbz_q, dbz_d;

  // Datapath of one restoring step.
  logic [16:0] shifted;
  logic [16:0] diff;
  logic        qbit;
  logic [15:0] prem_next;
  logic [15:0] quo_next;

  // Restoring step: bring in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    shifted   = {prem_q, dvd_q[15]};
    diff      = shifted - {1'b0, dvs_q};
    // Shifted value is below twice the divisor, so a negative difference
    // always shows up as bit 16 set.
    qbit      = ~diff[16];
    prem_next = qbit ? diff[15:0] : shifted[15:0];
    quo_next  = {dvd_q[14:0], qbit};
  end

  // Next-state and register-load logic for the three-state controller.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch to hold it.
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    out_d   = out_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          neg_q_d = INn1[15] ^ INn2[15];
          neg_r_d = INn1[15];
          // Magnitude of -32768 is 0x8000, which still fits 16 bits unsigned.
          dvd_d   = INn1[15] ? (~INn1 + 16'd1) : INn1;
          dvs_d   = INn2[15] ? (~INn2 + 16'd1) : INn2;
          prem_d  = 16'd0;
          cnt_d   = 5'd0;
          if (INn2 == 16'd0) begin
            state_d = DONE;
            out_d   = 16'd0;
            rem_d   = INn1;
            dbz_d   = 1'b1;
          end else begin
            state_d = DIV;
          end
        end
      end

      DIV: begin
        prem_d = prem_next;
        dvd_d  = quo_next;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = DONE;
          // Negation wraps, so -32768 / -1 yields 0x8000 with no flag.
          out_d   = neg_q_q ? (~quo_next + 16'd1) : quo_next;
          rem_d   = neg_r_q ? (~prem_next + 16'd1) : prem_next;
          dbz_d   = 1'b0;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value, independent of statement order.
    if (nRST) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      dvd_q   <= 16'd0;
      dvs_q   <= 16'd0;
      prem_q  <= 16'd0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      out_q   <= 16'd0;
      rem_q   <= 16'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign out         = out_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;
  assign finish      = (state_q == DONE);
  assign busy        = (state_q != IDLE);

endmodule
